// File: rtl/cmd_frame_decoder.sv
// Purpose : parses command frames from the synchronized RX byte stream into
//           register-file write/read strobes and ALU start strobes.
// Latency : every strobe is registered, 1 cycle after the completing byte.
// Backpr. : none; a byte is consumed whenever rx_valid=1, and a stalled frame
//           is aborted after TIMEOUT_CYCLES idle cycles.
// Ports   : CLK/RST (async active-low); rx_data/rx_valid byte input;
//           rf_addr/rf_wr_data/rf_wr_en/rf_rd_en register-file side;
//           alu_fun/alu_en/alu_clk_en ALU side; frame_err, busy status.
module cmd_frame_decoder #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [3:0]            alu_fun,
  output logic                  alu_en,
  output logic                  alu_clk_en,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]   addr_lat_q, addr_lat_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d;
  logic [3:0]              alu_fun_d;
  logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d;
  logic                    alu_clk_en_d, frame_err_d;
  logic                    expire;

  always_comb begin
    state_d      = state_q;
    tmo_d        = '0;
    addr_lat_d   = addr_lat_q;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    alu_fun_d    = alu_fun;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    frame_err_d  = 1'b0;

    // This is the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
    // A byte arriving in the same cycle keeps the frame alive.
    expire = (state_q != IDLE) && !rx_valid && (tmo_q == TMO_LAST);

    if ((state_q != IDLE) && !rx_valid && !expire)
      tmo_d = tmo_q + 1'b1;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == CMD_WR)       state_d = WR_ADDR;
          else if (rx_data == CMD_RD)  state_d = RD_ADDR;
          else if (rx_data == CMD_ALU) state_d = ALU_OPA;
          else if (rx_data == CMD_FUN) state_d = ALU_FUN;
          else                         frame_err_d = 1'b1;
        end
        WR_ADDR: begin
          // Held internally so rf_addr only moves when the write issues.
          addr_lat_d = rx_data[ADDR_WIDTH-1:0];
          state_d    = WR_DATA;
        end
        WR_DATA: begin
          rf_addr_d    = addr_lat_q;
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
        RD_ADDR: begin
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = IDLE;
        end
        ALU_OPA: begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_OPB;
        end
        ALU_OPB: begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FUN;
        end
        ALU_FUN: begin
          alu_fun_d = rx_data[3:0];
          alu_en_d  = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    // ALU clock runs for the whole ALU frame, the alu_en cycle and one
    // cycle after it (alu_en is the registered strobe of the last cycle).
    alu_clk_en_d = (state_d == ALU_OPA) || (state_d == ALU_OPB) ||
                   (state_d == ALU_FUN) || alu_en_d || alu_en;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      addr_lat_q <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      alu_clk_en <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      addr_lat_q <= addr_lat_d;
      rf_addr    <= rf_addr_d;
      rf_wr_data <= rf_wr_data_d;
      rf_wr_en   <= rf_wr_en_d;
      rf_rd_en   <= rf_rd_en_d;
      alu_fun    <= alu_fun_d;
      alu_en     <= alu_en_d;
      alu_clk_en <= alu_clk_en_d;
      frame_err  <= frame_err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Purpose : randomized and directed stimulus for cmd_frame_decoder, compared
//           against a frame-level reference model every cycle.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : n/a.
module tb_cmd_frame_decoder;

  localparam int TMO = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en, rf_rd_en;
  logic [3:0] alu_fun;
  logic       alu_en, alu_clk_en, frame_err, busy;

  int n_tot = 0;
  int n_bad = 0;

  cmd_frame_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_clk_en(alu_clk_en), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: collects the bytes of the current frame in a queue and
  // decides on each accepted byte whether the frame is complete.
  logic [7:0] frame[$];
  int         idle_n;
  logic [3:0] m_addr, m_fun;
  logic [7:0] m_data;
  logic       m_wr, m_rd, m_alu, m_alu_prev, m_err, m_busy, m_clk;

  function automatic void model_reset();
    frame.delete();
    idle_n = 0;
    m_addr = '0; m_fun = '0; m_data = '0;
    m_wr = 0; m_rd = 0; m_alu = 0; m_alu_prev = 0; m_err = 0;
    m_busy = 0; m_clk = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d);
    logic [7:0] c, b;
    int n;
    m_alu_prev = m_alu;
    m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0;
    if (v) begin
      idle_n = 0;
      frame.push_back(d);
      c = frame[0];
      n = frame.size();
      if (c != 8'hAA && c != 8'hBB && c != 8'hCC && c != 8'hDD) begin
        m_err = 1; frame.delete();
      end else if (c == 8'hAA && n == 3) begin
        b = frame[1]; m_addr = b[3:0]; m_data = frame[2]; m_wr = 1; frame.delete();
      end else if (c == 8'hBB && n == 2) begin
        b = frame[1]; m_addr = b[3:0]; m_rd = 1; frame.delete();
      end else if (c == 8'hCC && (n == 2 || n == 3)) begin
        m_addr = 4'(n - 2); m_data = frame[n-1]; m_wr = 1;
      end else if ((c == 8'hCC && n == 4) || (c == 8'hDD && n == 2)) begin
        b = frame[n-1]; m_fun = b[3:0]; m_alu = 1; frame.delete();
      end
    end else if (frame.size() > 0) begin
      idle_n++;
      if (idle_n == TMO) begin
        m_err = 1; frame.delete(); idle_n = 0;
      end
    end
    m_busy = (frame.size() != 0);
    m_clk  = m_alu || m_alu_prev;
    if (m_busy && (frame[0] == 8'hCC || frame[0] == 8'hDD)) m_clk = 1;
  endfunction

  function automatic logic [21:0] exp_vec();
    return {m_busy, m_err, m_clk, m_alu, m_fun, m_rd, m_wr, m_data, m_addr};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {busy, frame_err, alu_clk_en, alu_en, alu_fun, rf_rd_en, rf_wr_en,
            rf_wr_data, rf_addr};
  endfunction

  // One clock: present (v,d), advance the model, sample after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    model_step(v, d);
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  logic [8:0] seq[$];

  task automatic test_reset();
    RST = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    #3;
    n_tot++;
    if (dut_vec() !== 22'h0) begin
      n_bad++; $display("FAIL reset_outputs: got=%h want=%h", dut_vec(), 22'h0);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_idle%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_write();
    seq = '{9'h1AA, 9'h000, 9'h105, 9'h000, 9'h000, 9'h13C};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL write_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({rf_wr_en, rf_addr, rf_wr_data, busy} !== {1'b1, 4'h5, 8'h3C, 1'b0}) begin
      n_bad++;
      $display("FAIL write_strobe: got wr=%b addr=%h data=%h busy=%b want 1/5/3c/0",
               rf_wr_en, rf_addr, rf_wr_data, busy);
    end
    step(1'b0, 8'h00);
    n_tot++;
    if (rf_wr_en !== 1'b0 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL write_hold: got wr=%b addr=%h data=%h want 0/5/3c",
               rf_wr_en, rf_addr, rf_wr_data);
    end
  endtask

  task automatic test_read_trunc();
    seq = '{9'h1BB, 9'h000, 9'h11F};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL read_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({rf_rd_en, rf_wr_en, rf_addr} !== {1'b1, 1'b0, 4'hF}) begin
      n_bad++;
      $display("FAIL read_strobe: got rd=%b wr=%b addr=%h want 1/0/f",
               rf_rd_en, rf_wr_en, rf_addr);
    end
  endtask

  task automatic test_alu();
    seq = '{9'h1CC, 9'h112, 9'h000, 9'h134, 9'h102};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL alu_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
      if (i == 1) begin
        n_tot++;
        if ({rf_wr_en, rf_addr, rf_wr_data, alu_clk_en} !== {1'b1, 4'h0, 8'h12, 1'b1}) begin
          n_bad++;
          $display("FAIL alu_opa: got wr=%b addr=%h data=%h clk=%b want 1/0/12/1",
                   rf_wr_en, rf_addr, rf_wr_data, alu_clk_en);
        end
      end
      if (i == 3) begin
        n_tot++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h1, 8'h34}) begin
          n_bad++;
          $display("FAIL alu_opb: got wr=%b addr=%h data=%h want 1/1/34",
                   rf_wr_en, rf_addr, rf_wr_data);
        end
      end
    end
    n_tot++;
    if ({alu_en, alu_fun, alu_clk_en} !== {1'b1, 4'h2, 1'b1}) begin
      n_bad++;
      $display("FAIL alu_start: got en=%b fun=%h clk=%b want 1/2/1", alu_en, alu_fun, alu_clk_en);
    end
    step(1'b0, 8'h00);
    n_tot++;
    if ({alu_en, alu_clk_en} !== 2'b01) begin
      n_bad++; $display("FAIL alu_clk_tail: got en=%b clk=%b want 0/1", alu_en, alu_clk_en);
    end
    step(1'b0, 8'h00);
    n_tot++;
    if (alu_clk_en !== 1'b0) begin
      n_bad++; $display("FAIL alu_clk_fall: got clk=%b want 0", alu_clk_en);
    end
    seq = '{9'h1DD, 9'h1F5};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL fun_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({alu_en, alu_fun} !== {1'b1, 4'h5}) begin
      n_bad++; $display("FAIL fun_only: got en=%b fun=%h want 1/5", alu_en, alu_fun);
    end
  endtask

  task automatic test_bad_cmd();
    step(1'b1, 8'h77);
    n_tot++;
    if ({frame_err, busy} !== 2'b10 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL bad_cmd: got=%h want=%h", dut_vec(), exp_vec());
    end
    step(1'b0, 8'h00);
    n_tot++;
    if ({frame_err, busy} !== 2'b00) begin
      n_bad++; $display("FAIL bad_cmd_after: got err=%b busy=%b want 0/0", frame_err, busy);
    end
  endtask

  task automatic test_timeout();
    seq = '{9'h1AA, 9'h103};
    for (int i = 0; i < TMO; i++) seq.push_back(9'h000);
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL timeout_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({frame_err, busy, rf_wr_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%b busy=%b wr=%b want 1/0/0", frame_err, busy, rf_wr_en);
    end
    seq = '{9'h1AA, 9'h103, 9'h101};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL retry_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h3, 8'h01}) begin
      n_bad++;
      $display("FAIL retry_write: got wr=%b addr=%h data=%h want 1/3/01",
               rf_wr_en, rf_addr, rf_wr_data);
    end
  endtask

  task automatic test_expiry_boundary();
    seq = '{9'h1AA, 9'h103};
    for (int i = 0; i < TMO - 1; i++) seq.push_back(9'h000);
    seq.push_back(9'h101);
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL expiry_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    n_tot++;
    if ({rf_wr_en, frame_err, rf_wr_data} !== {1'b1, 1'b0, 8'h01}) begin
      n_bad++;
      $display("FAIL expiry_byte_wins: got wr=%b err=%b data=%h want 1/0/01",
               rf_wr_en, frame_err, rf_wr_data);
    end
    step(1'b0, 8'h00);
    n_tot++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL expiry_no_err: got err=%b want 0", frame_err);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hCC);
    step(1'b1, 8'h11);
    n_tot++;
    if ({busy, alu_clk_en} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre: got busy=%b clk=%b want 1/1", busy, alu_clk_en);
    end
    RST = 1'b0;
    model_reset();
    #2;
    n_tot++;
    if (dut_vec() !== 22'h0) begin
      n_bad++; $display("FAIL rst_mid: got=%h want=%h", dut_vec(), 22'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    seq = '{9'h000, 9'h1DD, 9'h101, 9'h000, 9'h000};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rst_after%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    // Command values used as payload, frames with no gap between them.
    seq = '{9'h1AA, 9'h1AA, 9'h1BB, 9'h1BB, 9'h1CC, 9'h1DD, 9'h1DD,
            9'h1CC, 9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD, 9'h1DD, 9'h177, 9'h000, 9'h000};
    foreach (seq[i]) begin
      step(seq[i][8], seq[i][7:0]);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL b2b_step%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
      if (i == 2) begin
        n_tot++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'hA, 8'hBB}) begin
          n_bad++;
          $display("FAIL b2b_payload: got wr=%b addr=%h data=%h want 1/a/bb",
                   rf_wr_en, rf_addr, rf_wr_data);
        end
      end
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] d;
    int         r;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < TMO + 1; k++) begin
          step(1'b0, 8'h00);
          n_tot++;
          if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL rand_gap%0d_%0d: got=%h want=%h", i, k, dut_vec(), exp_vec());
          end
        end
      end
      v = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 6);
      case (r)
        0: d = 8'hAA;
        1: d = 8'hBB;
        2: d = 8'hCC;
        3: d = 8'hDD;
        default: d = 8'($urandom);
      endcase
      step(v, d);
      n_tot++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rand%0d: got=%h want=%h", i, dut_vec(), exp_vec());
      end
      n_tot++;
      if (32'(rf_wr_en) + 32'(rf_rd_en) + 32'(alu_en) + 32'(frame_err) > 1) begin
        n_bad++;
        $display("FAIL rand_excl%0d: got wr=%b rd=%b alu=%b err=%b want at most one",
                 i, rf_wr_en, rf_rd_en, alu_en, frame_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_trunc();
    test_alu();
    test_bad_cmd();
    test_timeout();
    test_expiry_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
